// File: rtl/player_shot.sv
// Player bullet controller: launches one bullet per fire press, walks it up the
// invader rows, retires it on a hit or off the top row, then enforces a cooldown.
module player_shot #(
    parameter int COLS           = 20,
    parameter int ROWS           = 8,
    parameter int STEP_TICKS     = 1000000,
    parameter int COOLDOWN_TICKS = 250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fire,
    input  logic [4:0] player_col,
    input  logic       hit,
    output logic       bullet_active,
    output logic [4:0] bullet_x,
    output logic [2:0] bullet_y,
    output logic       shot,
    output logic       miss
);

    localparam int STEP_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam int COOL_W = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;

    localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(STEP_TICKS - 1);
    localparam logic [COOL_W-1:0] COOL_LAST  = COOL_W'((COOLDOWN_TICKS > 0) ? COOLDOWN_TICKS - 1 : 0);
    localparam logic [4:0]        COL_MAX    = 5'(COLS - 1);
    localparam logic [2:0]        ROW_BOTTOM = 3'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FLIGHT,
        COOLDOWN
    } state_t;

    state_t            state_q, state_d;
    logic              armed_q, armed_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [COOL_W-1:0] cool_q, cool_d;
    logic              active_d, shot_d, miss_d;
    logic [4:0]        x_d;
    logic [2:0]        y_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d  = state_q;
        armed_d  = armed_q | ~fire;
        step_d   = step_q;
        cool_d   = cool_q;
        active_d = bullet_active;
        x_d      = bullet_x;
        y_d      = bullet_y;
        shot_d   = 1'b0;
        miss_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (fire && armed_q) begin
                    state_d  = FLIGHT;
                    armed_d  = 1'b0;
                    active_d = 1'b1;
                    x_d      = (player_col > COL_MAX) ? COL_MAX : player_col;
                    y_d      = ROW_BOTTOM;
                    shot_d   = 1'b1;
                    step_d   = '0;
                end
            end

            FLIGHT: begin
                // A hit beats a coincident row step; leaving row 0 is a miss.
                if (hit || (step_q == STEP_LAST && bullet_y == 3'd0)) begin
                    state_d  = (COOLDOWN_TICKS == 0) ? IDLE : COOLDOWN;
                    active_d = 1'b0;
                    x_d      = '0;
                    y_d      = '0;
                    miss_d   = ~hit;
                    step_d   = '0;
                    cool_d   = '0;
                end else if (step_q == STEP_LAST) begin
                    y_d    = bullet_y - 3'd1;
                    step_d = '0;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end

            COOLDOWN: begin
                if (cool_q == COOL_LAST) begin
                    state_d = IDLE;
                end else begin
                    cool_d = cool_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q       <= IDLE;
            armed_q       <= 1'b1;
            step_q        <= '0;
            cool_q        <= '0;
            bullet_active <= 1'b0;
            bullet_x      <= '0;
            bullet_y      <= '0;
            shot          <= 1'b0;
            miss          <= 1'b0;
        end else begin
            state_q       <= state_d;
            armed_q       <= armed_d;
            step_q        <= step_d;
            cool_q        <= cool_d;
            bullet_active <= active_d;
            bullet_x      <= x_d;
            bullet_y      <= y_d;
            shot          <= shot_d;
            miss          <= miss_d;
        end
    end

endmodule

// File: tb/tb_player_shot.sv
// Self-checking bench for player_shot: two parameterisations driven by the same
// stimulus, checked every cycle against a timestamp-based reference model.
module tb_player_shot;

    localparam int COLS = 20;
    localparam int ROWS = 8;
    localparam int NDUT = 2;

    logic       clk;
    logic       reset;
    logic       fire;
    logic       hit;
    logic [4:0] player_col;

    logic       act  [NDUT];
    logic [4:0] bx   [NDUT];
    logic [2:0] by   [NDUT];
    logic       shot [NDUT];
    logic       miss [NDUT];

    int n_checks = 0;
    int n_pass   = 0;
    int edge_n   = 0;

    // Reference model: flight timing derived from launch/retire timestamps.
    bit m_fl    [NDUT];
    bit m_armed [NDUT];
    int m_launch[NDUT];
    int m_ready [NDUT];
    int e_act   [NDUT];
    int e_x     [NDUT];
    int e_y     [NDUT];
    int e_shot  [NDUT];
    int e_miss  [NDUT];

    player_shot #(.COLS(COLS), .ROWS(ROWS), .STEP_TICKS(4), .COOLDOWN_TICKS(3)) dut0 (
        .clk(clk), .reset(reset), .fire(fire), .player_col(player_col), .hit(hit),
        .bullet_active(act[0]), .bullet_x(bx[0]), .bullet_y(by[0]), .shot(shot[0]), .miss(miss[0])
    );

    player_shot #(.COLS(COLS), .ROWS(ROWS), .STEP_TICKS(1), .COOLDOWN_TICKS(0)) dut1 (
        .clk(clk), .reset(reset), .fire(fire), .player_col(player_col), .hit(hit),
        .bullet_active(act[1]), .bullet_x(bx[1]), .bullet_y(by[1]), .shot(shot[1]), .miss(miss[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int step_of(int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int cool_of(int i);
        return (i == 0) ? 3 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
        else n_pass++;
    endtask

    task automatic model_edge(input int i);
        int st;
        int cd;
        int age;
        st = step_of(i);
        cd = cool_of(i);
        e_shot[i] = 0;
        e_miss[i] = 0;
        if (reset) begin
            m_fl[i] = 0; m_armed[i] = 1; m_ready[i] = edge_n + 1;
            e_act[i] = 0; e_x[i] = 0; e_y[i] = 0;
            return;
        end
        if (m_fl[i]) begin
            age = edge_n - m_launch[i] - 1;
            if (hit || age == ROWS * st - 1) begin
                m_fl[i] = 0;
                e_act[i] = 0; e_x[i] = 0; e_y[i] = 0;
                e_miss[i] = hit ? 0 : 1;
                m_ready[i] = edge_n + cd + 1;
            end else begin
                e_y[i] = ROWS - 1 - (age + 1) / st;
            end
        end else if (edge_n >= m_ready[i] && fire && m_armed[i]) begin
            m_fl[i] = 1; m_launch[i] = edge_n; m_armed[i] = 0;
            e_act[i] = 1; e_shot[i] = 1; e_y[i] = ROWS - 1;
            e_x[i] = (int'(player_col) >= COLS) ? COLS - 1 : int'(player_col);
        end
        if (!fire) m_armed[i] = 1;
    endtask

    task automatic compare_all();
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("d%0d_active", i), act[i],  e_act[i]);
            check($sformatf("d%0d_x", i),      bx[i],   e_x[i]);
            check($sformatf("d%0d_y", i),      by[i],   e_y[i]);
            check($sformatf("d%0d_shot", i),   shot[i], e_shot[i]);
            check($sformatf("d%0d_miss", i),   miss[i], e_miss[i]);
        end
    endtask

    // One clock: model sees the inputs sampled at the edge, outputs are compared mid-cycle.
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < NDUT; i++) model_edge(i);
        edge_n++;
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1; fire = 1'b0; hit = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    int shots;

    initial begin
        reset = 1'b1; fire = 1'b0; hit = 1'b0; player_col = '0;
        for (int i = 0; i < NDUT; i++) begin
            m_fl[i] = 0; m_armed[i] = 1; m_launch[i] = 0; m_ready[i] = 0;
            e_act[i] = 0; e_x[i] = 0; e_y[i] = 0; e_shot[i] = 0; e_miss[i] = 0;
        end
        @(negedge clk);

        // Full unhit flight, miss pulse, cooldown, relaunch only once IDLE.
        do_reset();
        check("rst_active", act[0], 0);
        check("rst_shot", shot[0], 0);
        player_col = 5'd9; fire = 1'b1;
        tick();
        check("s1_active", act[0], 1);
        check("s1_x", bx[0], 9);
        check("s1_y", by[0], 7);
        check("s1_shot", shot[0], 1);
        fire = 1'b0;
        for (int k = 2; k <= 37; k++) begin
            tick();
            if (k == 2)  check("s1_shot_drop", shot[0], 0);
            if (k == 4)  check("s1_y_t4", by[0], 7);
            if (k == 5)  check("s1_y_t5", by[0], 6);
            if (k == 29) check("s1_y_t29", by[0], 0);
            if (k == 32) check("s1_active_t32", act[0], 1);
            if (k == 33) begin
                check("s1_active_t33", act[0], 0);
                check("s1_miss_t33", miss[0], 1);
            end
            if (k == 34) check("s1_miss_t34", miss[0], 0);
            if (k == 35) fire = 1'b1;
            if (k == 36) check("s1_no_fire_in_cooldown", shot[0], 0);
            if (k == 37) check("s1_relaunch_t37", shot[0], 1);
        end

        // Column clamp and column held for the whole flight.
        do_reset();
        player_col = 5'd25; fire = 1'b1;
        tick();
        check("clamp_x", bx[0], 19);
        fire = 1'b0; player_col = 5'd3;
        repeat (5) tick();
        check("clamp_hold_x", bx[0], 19);
        check("clamp_hold_active", act[0], 1);

        // Hit mid-flight, fire ignored during cooldown, launch once IDLE.
        do_reset();
        player_col = 5'd5; fire = 1'b1;
        tick();
        fire = 1'b0;
        repeat (9) tick();
        hit = 1'b1;
        tick();
        hit = 1'b0;
        check("hit_active", act[0], 0);
        check("hit_x", bx[0], 0);
        check("hit_miss", miss[0], 0);
        fire = 1'b1;
        repeat (3) tick();
        check("hit_cooldown_no_shot", act[0], 0);
        tick();
        check("hit_relaunch_shot", shot[0], 1);
        check("hit_relaunch_x", bx[0], 5);
        fire = 1'b0;

        // Hit coinciding with the first row step.
        do_reset();
        fire = 1'b1; player_col = 5'd12;
        tick();
        fire = 1'b0;
        repeat (3) tick();
        hit = 1'b1;
        tick();
        hit = 1'b0;
        check("hit_step_active", act[0], 0);
        check("hit_step_y", by[0], 0);
        check("hit_step_miss", miss[0], 0);

        // Fire held from reset: a single shot, no auto-repeat.
        reset = 1'b1; fire = 1'b1; hit = 1'b0;
        tick();
        reset = 1'b0;
        shots = 0;
        repeat (60) begin
            tick();
            if (shot[0]) shots++;
        end
        check("hold_single_shot", shots, 1);
        fire = 1'b0;
        tick();
        fire = 1'b1;
        shots = 0;
        repeat (3) begin
            tick();
            if (shot[0]) shots++;
        end
        check("rearm_shot", shots, 1);

        // Reset mid-flight: bullet vanishes, no miss, immediately re-armed.
        do_reset();
        fire = 1'b1;
        tick();
        fire = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_flight_active", act[0], 0);
        check("rst_flight_miss", miss[0], 0);
        fire = 1'b1;
        tick();
        check("rst_flight_relaunch", shot[0], 1);

        // Randomised traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            fire       = ($urandom_range(0, 2) != 0);
            hit        = ($urandom_range(0, 19) == 0);
            player_col = 5'($urandom_range(0, 31));
            reset      = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
